// File: rtl/ir_sensor_array.sv
// Multi-channel IR sensor front end: synchronise, debounce on a prescaled tick,
// normalise polarity, and report edges, saturating event counts and the latest channel.
module ir_sensor_array #(
  parameter int CH         = 4,
  parameter int DIV        = 10,
  parameter int STABLE     = 6,
  parameter int ACTIVE_LOW = 1,
  parameter int CNT_W      = 8,
  parameter int IDX_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         signal,
  input  logic                  clr_cnt,
  output logic [CH-1:0]         det,
  output logic [CH-1:0]         rise,
  output logic [CH-1:0]         fall,
  output logic [CH*CNT_W-1:0]   cnt,
  output logic                  any_det,
  output logic [IDX_W-1:0]      last_ch
);

  localparam int SW = (STABLE > 1) ? $clog2(STABLE) : 1;
  localparam logic INACT = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CH-1:0]    sync1_r;
  logic [CH-1:0]    sync2_r;
  logic [CH-1:0]    act_s;
  logic [CH-1:0]    det_r;
  logic [CH-1:0]    det_prev_r;
  logic [CH-1:0]    rise_s;
  logic [CH-1:0]    fall_s;
  logic [DIV-1:0]   presc_r;
  logic             tick_s;
  logic [SW-1:0]    stab_r [CH];
  logic [CNT_W-1:0] cnt_r [CH];
  logic [IDX_W-1:0] last_ch_r;
  logic [IDX_W-1:0] first_rise_s;

  // Two-flop synchroniser; idles at the inactive line level so release is quiet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= {CH{INACT}};
      sync2_r <= {CH{INACT}};
    end else begin
      sync1_r <= signal;
      sync2_r <= sync1_r;
    end
  end

  assign act_s = sync2_r ^ {CH{INACT}};

  // Free-running sample prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {DIV{1'b0}};
    end else begin
      presc_r <= presc_r + 1'b1;
    end
  end

  assign tick_s = &presc_r;

  // Debounce: any sample matching det restarts qualification
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_r <= {CH{1'b0}};
      for (int i = 0; i < CH; i++) stab_r[i] <= {SW{1'b0}};
    end else if (tick_s) begin
      for (int i = 0; i < CH; i++) begin
        if (act_s[i] == det_r[i]) begin
          stab_r[i] <= {SW{1'b0}};
        end else if (stab_r[i] == STAB_MAX) begin
          det_r[i]  <= act_s[i];
          stab_r[i] <= {SW{1'b0}};
        end else begin
          stab_r[i] <= stab_r[i] + 1'b1;
        end
      end
    end
  end

  // Previous debounced level for edge extraction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      det_prev_r <= {CH{1'b0}};
    end else begin
      det_prev_r <= det_r;
    end
  end

  assign rise_s = det_r & ~det_prev_r;
  assign fall_s = ~det_r & det_prev_r;

  // Saturating event counters; clear wins over a same-cycle rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (clr_cnt) begin
          cnt_r[i] <= {CNT_W{1'b0}};
        end else if (rise_s[i] && (cnt_r[i] != CNT_MAX)) begin
          cnt_r[i] <= cnt_r[i] + 1'b1;
        end
      end
    end
  end

  // Lowest-index channel among the current rise pulses
  always_comb begin
    first_rise_s = {IDX_W{1'b0}};
    for (int i = CH - 1; i >= 0; i--) begin
      first_rise_s = rise_s[i] ? IDX_W'(i) : first_rise_s;
    end
  end

  // Most recent rising channel, held between events
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_ch_r <= {IDX_W{1'b0}};
    end else if (|rise_s) begin
      last_ch_r <= first_rise_s;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CH; g++) begin : g_cnt
      assign cnt[g*CNT_W +: CNT_W] = cnt_r[g];
    end
  endgenerate

  assign det     = det_r;
  assign rise    = rise_s;
  assign fall    = fall_s;
  assign any_det = |det_r;
  assign last_ch = last_ch_r;

endmodule

// File: tb/tb_ir_sensor_array.sv
// Bench for ir_sensor_array: active-low and active-high instances driven with mirrored
// pins, compared every clock against a tick-sample-window reference model.
module tb_ir_sensor_array;

  logic       clk;
  logic       rst;
  logic [3:0] signal;
  logic [3:0] signal_h;
  logic       clr_cnt;

  logic [3:0] det, rise, fall, det_h, rise_h, fall_h;
  logic [7:0] cnt, cnt_h;
  logic       any_det, any_det_h;
  logic [1:0] last_ch, last_ch_h;

  assign signal_h = ~signal;

  ir_sensor_array #(.CH(4), .DIV(2), .STABLE(3), .ACTIVE_LOW(1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .signal(signal), .clr_cnt(clr_cnt),
    .det(det), .rise(rise), .fall(fall), .cnt(cnt),
    .any_det(any_det), .last_ch(last_ch)
  );

  ir_sensor_array #(.CH(4), .DIV(2), .STABLE(3), .ACTIVE_LOW(0), .CNT_W(2)) dut_h (
    .clk(clk), .rst(rst), .signal(signal_h), .clr_cnt(clr_cnt),
    .det(det_h), .rise(rise_h), .fall(fall_h), .cnt(cnt_h),
    .any_det(any_det_h), .last_ch(last_ch_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: det flips once the last 3 tick samples all disagree with it
  logic [3:0] det_m, rise_m, fall_m;
  logic [1:0] cnt_m [4];
  logic [1:0] last_m;
  logic [3:0] pipe_q [$];
  logic [3:0] samp_q [$];
  int         e_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    det_m = 4'h0; rise_m = 4'h0; fall_m = 4'h0; last_m = 2'd0;
    for (int i = 0; i < 4; i++) cnt_m[i] = 2'd0;
    pipe_q = '{4'hF, 4'hF};
    samp_q.delete();
    e_m = 0;
  endtask

  task automatic model_edge(input logic [3:0] pin, input logic clr);
    logic [3:0] old_det, s;
    bit         all_diff;
    for (int i = 0; i < 4; i++) begin
      if (clr) cnt_m[i] = 2'd0;
      else if (rise_m[i] && cnt_m[i] != 2'd3) cnt_m[i] = cnt_m[i] + 2'd1;
    end
    if (rise_m != 4'h0)
      for (int i = 3; i >= 0; i--) if (rise_m[i]) last_m = 2'(i);
    old_det = det_m;
    pipe_q.push_back(pin);
    s = pipe_q.pop_front();
    if (e_m % 4 == 3) begin
      samp_q.push_back(~s);
      if (samp_q.size() > 3) void'(samp_q.pop_front());
      if (samp_q.size() == 3) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < 3; k++) if (samp_q[k][i] == old_det[i]) all_diff = 1'b0;
          if (all_diff) det_m[i] = ~old_det[i];
        end
      end
    end
    e_m++;
    rise_m = det_m & ~old_det;
    fall_m = ~det_m & old_det;
  endtask

  function automatic int trail(input int ch);
    int n = 0;
    for (int k = samp_q.size() - 1; k >= 0; k--) begin
      if (samp_q[k][ch] != det_m[ch]) n++;
      else break;
    end
    return n;
  endfunction

  task automatic check_all();
    logic [7:0] cexp;
    cexp = {cnt_m[3], cnt_m[2], cnt_m[1], cnt_m[0]};
    chk("det",       32'(det),       32'(det_m));
    chk("rise",      32'(rise),      32'(rise_m));
    chk("fall",      32'(fall),      32'(fall_m));
    chk("cnt",       32'(cnt),       32'(cexp));
    chk("any_det",   32'(any_det),   32'(|det_m));
    chk("last_ch",   32'(last_ch),   32'(last_m));
    chk("det_h",     32'(det_h),     32'(det_m));
    chk("rise_h",    32'(rise_h),    32'(rise_m));
    chk("fall_h",    32'(fall_h),    32'(fall_m));
    chk("cnt_h",     32'(cnt_h),     32'(cexp));
    chk("any_det_h", 32'(any_det_h), 32'(|det_m));
    chk("last_ch_h", 32'(last_ch_h), 32'(last_m));
  endtask

  task automatic step();
    logic [3:0] pin;
    logic       c;
    pin = signal;
    c   = clr_cnt;
    @(posedge clk);
    if (!rst) model_edge(pin, c);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int n;
    bit found;
    rst = 1'b1; signal = 4'hF; clr_cnt = 1'b0;
    model_reset();
    #1;
    check_all();
    steps(3);
    rst = 1'b0;

    // Idle with all lines inactive
    steps(200);

    // Clean detect on channel 2
    signal[2] = 1'b0;
    n = 0; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(); n++;
      if (det[2]) found = 1'b1;
    end
    chk("det2_seen", 32'(found), 32'd1);
    chk("det2_latency_le14", 32'(n <= 14), 32'd1);
    chk("cnt2_pre", 32'(cnt[5:4]), 32'd0);
    step();
    chk("cnt2_after_rise", 32'(cnt[5:4]), 32'd1);
    chk("last_ch_is2", 32'(last_ch), 32'd2);
    steps(60 - n - 1);
    signal[2] = 1'b1;
    steps(40);
    chk("cnt2_after_fall", 32'(cnt[5:4]), 32'd1);

    // Glitch shorter than qualification on channel 1
    signal[1] = 1'b0;
    steps(7);
    signal[1] = 1'b1;
    steps(30);
    chk("glitch_cnt1", 32'(cnt[3:2]), 32'd0);

    // Simultaneous rise on channels 1 and 3
    signal[3] = 1'b0; signal[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (rise != 4'h0) found = 1'b1;
    end
    chk("simul_rise_vec", 32'(rise), 32'hA);
    step();
    chk("simul_last_ch", 32'(last_ch), 32'd1);
    chk("simul_cnt3", 32'(cnt[7:6]), 32'd1);
    signal = 4'hF;
    steps(30);

    // Five qualified pulses on ch0 saturate the 2-bit counter
    for (int p = 0; p < 5; p++) begin
      signal[0] = 1'b0; steps(20);
      signal[0] = 1'b1; steps(20);
    end
    chk("sat_cnt0", 32'(cnt[1:0]), 32'd3);
    signal[0] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      if (rise_m[0]) found = 1'b1;
    end
    chk("sixth_rise_seen", 32'(found), 32'd1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_over_rise", 32'(cnt[1:0]), 32'd0);
    signal[0] = 1'b1;
    steps(30);

    // Randomised lines and clears
    for (int r = 0; r < 30; r++) begin
      signal  = 4'($urandom);
      clr_cnt = ($urandom_range(0, 9) == 0);
      step();
      clr_cnt = 1'b0;
      steps($urandom_range(2, 24));
    end
    signal = 4'hF;
    steps(30);

    // Asynchronous reset mid-operation
    signal[0] = 1'b0;
    steps(20);
    chk("mid_det0_set", 32'(det[0]), 32'd1);
    signal[1] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (trail(1) == 2) found = 1'b1;
    end
    chk("ch1_stab2_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("async_cnt_clear", 32'(cnt), 32'd0);
    signal[1] = 1'b1;
    steps(3);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (rise[0]) n++;
      if (i == 9) chk("no_early_requal", 32'(det[0]), 32'd0);
    end
    chk("rise0_once", 32'(n), 32'd1);
    chk("det1_after_reset", 32'(det[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
